latch_wr_sched: RTL and testbench
=================================

# latch_wr_sched

Write scheduler for a bank of 8-bit transparent latches with enable and async reset. It shares one latch data bus among several requesters using round-robin arbitration and sequences every write as data setup, a single-cycle enable pulse, then data hold, so a latch is never transparent while its data is changing. It also issues a bank-wide clear. It sits between the register-write sources and the latch bank, and is the only driver of the bank's `d`, `en` and `rst` pins.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `NLATCH`, 4: number of latches in the bank, 1..16. `AW = max(1, clog2(NLATCH))`.
- `SETUP`, 1: cycles `lat_d` is stable before the enable pulse, 1..15.
- `HOLD`, 1: cycles `lat_d` is held after the enable pulse, 1..15.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset rst, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester write request.
- `req_addr`  in  NREQ*AW  target latch index; requester i occupies slice [i*AW +: AW].
- `req_data`  in  NREQ*8  write byte; requester i occupies slice [i*8 +: 8].
- `req_ready`  out  NREQ  one-hot grant; a transfer happens on the cycle where valid & ready.
- `clr_req`  in  1  bank clear request, level-sensitive.
- `clr_done`  out  1  one-cycle pulse on the cycle the clear is issued.
- `lat_d`  out  8  shared latch data bus.
- `lat_en`  out  NLATCH  one-hot enable pulse.
- `lat_rst`  out  1  bank reset.
- `busy`  out  1  high whenever state != IDLE.
- `err_oob`  out  1  one-cycle pulse when an accepted address is ≥ NLATCH.

## Operation
- FSM states: IDLE, SETUP, EN, HOLD, CLR.
- **IDLE, clear pending:** if `clr_req`=1, go to CLR. Clear has priority over pending writes, and `req_ready` stays 0 that cycle.
- **IDLE, write pending:** else if any `req_valid`, the round-robin grant picks the first valid requester at or after `rr_ptr`, wrapping.
  - `req_ready[g]` is driven combinationally high this cycle.
  - `req_addr[g]` and `req_data[g]` are captured, and `lat_d` is registered from `req_data[g]`.
  - `rr_ptr` becomes (g+1) mod NREQ, and the FSM goes to SETUP.
- **`req_ready` rule:** `req_ready` is only ever high in IDLE and is at most one-hot.
- **Requester obligation:** a requester must hold valid/addr/data until it sees ready. Dropping valid before the grant is legal and simply withdraws the request.
- **SETUP:** count SETUP cycles; `lat_en`=0 and `lat_d` is stable. Then go to EN.
- **EN:** exactly one cycle, `lat_en[addr]`=1 (registered output).
  - If addr ≥ NLATCH, `lat_en` stays all-zero and `err_oob` pulses this cycle; the sequence still completes.
  - Then go to HOLD.
- **HOLD:** count HOLD cycles with `lat_d` unchanged, then go to IDLE.
- **CLR:** one cycle with `lat_rst`=1 and `clr_done`=1, then go to IDLE. `clr_req` still high on return starts another clear.
- **`lat_d` between writes:** keeps the last written value; it changes only on a grant edge.
- **`lat_rst` definition:** registered CLR indication OR'd with `rst`, so the bank is cleared for the whole time the controller is in reset.
- **Reset values:** state=IDLE, `rr_ptr`=0, `lat_d`=0, `lat_en`=0, `req_ready`=0, `clr_done`=0, `err_oob`=0, `busy`=0.
- **Reset mid-sequence:** the in-flight write is abandoned. `lat_en` is 0 from the first clocked reset edge, and the requester is not re-granted.

## Timing
- Grant on cycle t; `lat_d` is valid from t+1.
- `lat_en` is high on cycle t+SETUP+1.
- The FSM returns to IDLE on t+SETUP+HOLD+2; the next grant may occur on that cycle.
- Write period is SETUP+HOLD+2 cycles; with defaults, 4 cycles per write.
- Clear: `clr_req` seen in IDLE on t; `lat_rst`/`clr_done` high on t+1; IDLE on t+2.
- All outputs except `req_ready` are registered. `req_ready` is a combinational function of state, `req_valid`, `rr_ptr` and `clr_req`.

## Structure
- **Package `latch_sched_pkg`:**
  - `state_t` enum: IDLE, SETUP, EN, HOLD, CLR.
  - Counter width constant `CW`=4.
  - Function `addr_w(n)` returning max(1, clog2(n)).
- **Sub-module `rr_arbiter`:** parameter N; inputs `req`, `ptr`, `en`; outputs one-hot `gnt` and `gnt_idx`. The main block owns the `rr_ptr` update.

## Test plan
- **Single write, defaults:** req 1 valid, addr=2, data=0xA5.
  - `req_ready[1]` on t, `lat_d`=0xA5 from t+1, `lat_en`=4'b0100 only on t+2, `busy` low on t+4.
- **Round-robin:** all 4 requesters hold valid.
  - Grant order is 0,1,2,3,0 at 4-cycle spacing.
  - `lat_d` changes only on grant edges, never while any `lat_en` bit is high.
- **Clear priority:** `clr_req`=1 and req 0 valid together in IDLE.
  - `lat_rst`=1 and `clr_done`=1 on t+1, `req_ready[0]` stays 0; the grant to req 0 follows at t+2.
- **Reset during EN:** assert `rst` on the cycle `lat_en` is high.
  - `lat_en`=0 and `lat_rst`=1 while `rst` is high; after release, state is IDLE, `rr_ptr`=0, `lat_d`=0.
- **Out-of-range address:** NLATCH=3, addr=3.
  - No `lat_en` bit is ever set, `err_oob` pulses on the EN cycle, and the next grant comes 4 cycles after the first.
- **SETUP=3, HOLD=2:** `lat_en` on t+4, IDLE on t+7; `lat_d` is unchanged from t+1 through t+6.

Source files
------------

// File: rtl/latch_wr_sched_pkg.sv
// Shared types and helpers for the latch write scheduler.
package latch_sched_pkg;

  // Width of the setup/hold cycle counter; covers SETUP/HOLD up to 15.
  localparam int CW = 4;

  // Controller sequence: setup, enable pulse, hold, or a bank clear.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN,
    ST_HOLD,
    ST_CLR
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/latch_wr_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// The pointer itself is owned and advanced by the instantiating block.
module rr_arbiter
  import latch_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = addr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] w_idx;
  logic          w_found;

  // Scan requesters starting at ptr and take the first valid one.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a value unassigned, which would infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(ptr) + k) % N);
      if (en && !w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/latch_wr_sched.sv
// Write scheduler for a bank of transparent latches. Arbitrates the shared
// data bus round-robin and sequences each write as setup, one-cycle enable,
// then hold, so a latch is never open while its data is moving. Also issues
// a bank-wide clear, which wins over pending writes.
module latch_wr_sched
  import latch_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int NLATCH = 4,
  parameter int SETUP  = 1,
  parameter int HOLD   = 1,
  parameter int AW     = addr_w(NLATCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*8-1:0]  req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               clr_req,
  output logic               clr_done,
  output logic [7:0]         lat_d,
  output logic [NLATCH-1:0]  lat_en,
  output logic               lat_rst,
  output logic               busy,
  output logic               err_oob
);

  localparam int PW = addr_w(NREQ);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [PW-1:0]       r_rr_ptr;
  logic [AW-1:0]       r_addr;
  logic [7:0]          r_lat_d;
  logic [NLATCH-1:0]   r_lat_en;
  logic                r_clr;
  logic                r_busy;
  logic                r_err_oob;

  logic                w_arb_en;
  logic [NREQ-1:0]     w_gnt;
  logic [PW-1:0]       w_gnt_idx;
  logic                w_grant;
  logic [AW-1:0]       w_sel_addr;
  logic [7:0]          w_sel_data;
  logic [NLATCH-1:0]   w_en_dec;
  logic                w_fire_en;

  // Grants are only offered in IDLE, and a pending clear suppresses them.
  assign w_arb_en = (r_state == ST_IDLE) && !clr_req;
  assign w_grant  = |w_gnt;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .en      (w_arb_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // Route the granted requester's address and data onto the capture path.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_data = req_data[i*8 +: 8];
      end
    end
  end

  // Decode the captured address; an out-of-range address decodes to zero.
  always_comb begin
    w_en_dec = '0;
    for (int i = 0; i < NLATCH; i++) begin
      w_en_dec[i] = (r_addr == AW'(i));
    end
  end

  // Next-state and setup/hold counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clr_req) begin
          w_state_nxt = ST_CLR;
        end else if (w_grant) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = '0;
        end
      end
      ST_SETUP: begin
        if (r_cnt == CW'(SETUP - 1)) begin
          w_state_nxt = ST_EN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_EN: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = '0;
      end
      ST_HOLD: begin
        if (r_cnt == CW'(HOLD - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_CLR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The enable pulse is launched on the edge that leaves SETUP.
  assign w_fire_en = (r_state == ST_SETUP) && (w_state_nxt == ST_EN);

  // State register and counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered latch-bank outputs, capture of the granted write, pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_addr    <= '0;
      r_lat_d   <= '0;
      r_lat_en  <= '0;
      r_clr     <= 1'b0;
      r_busy    <= 1'b0;
      r_err_oob <= 1'b0;
    end else begin
      r_lat_en  <= w_fire_en ? w_en_dec : '0;
      r_err_oob <= w_fire_en && !(|w_en_dec);
      r_clr     <= (w_state_nxt == ST_CLR);
      r_busy    <= (w_state_nxt != ST_IDLE);
      if (w_grant) begin
        r_addr   <= w_sel_addr;
        r_lat_d  <= w_sel_data;
        r_rr_ptr <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  assign req_ready = w_gnt;
  assign lat_d     = r_lat_d;
  assign lat_en    = r_lat_en;
  assign clr_done  = r_clr;
  // The bank stays cleared for the whole time this controller is in reset.
  assign lat_rst   = r_clr | rst;
  assign busy      = r_busy;
  assign err_oob   = r_err_oob;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Bench for latch_wr_sched: two instances (default timing with 4 latches, and
// SETUP=3/HOLD=2 with 3 latches) driven by directed then random requests and
// compared cycle by cycle against a timeline model of the write schedule.
module tb_latch_wr_sched;

  localparam int NREQ = 4;
  localparam int AW   = 2;
  localparam int MAXC = 4096;
  localparam int LAST = 2300;

  int s_p  [2] = '{1, 3};
  int h_p  [2] = '{1, 2};
  int nl_p [2] = '{4, 3};

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req_valid [2];
  logic [NREQ*AW-1:0] req_addr  [2];
  logic [NREQ*8-1:0]  req_data  [2];
  logic               clr_req   [2];

  logic [NREQ-1:0] a_ready, b_ready;
  logic            a_clr_done, b_clr_done;
  logic [7:0]      a_lat_d, b_lat_d;
  logic [3:0]      a_lat_en;
  logic [2:0]      b_lat_en;
  logic            a_lat_rst, b_lat_rst;
  logic            a_busy, b_busy;
  logic            a_oob, b_oob;

  always #5 clk = ~clk;

  latch_wr_sched #(.NREQ(4), .NLATCH(4), .SETUP(1), .HOLD(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_data(req_data[0]),
    .req_ready(a_ready), .clr_req(clr_req[0]), .clr_done(a_clr_done),
    .lat_d(a_lat_d), .lat_en(a_lat_en), .lat_rst(a_lat_rst),
    .busy(a_busy), .err_oob(a_oob)
  );

  latch_wr_sched #(.NREQ(4), .NLATCH(3), .SETUP(3), .HOLD(2)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_data(req_data[1]),
    .req_ready(b_ready), .clr_req(clr_req[1]), .clr_done(b_clr_done),
    .lat_d(b_lat_d), .lat_en(b_lat_en), .lat_rst(b_lat_rst),
    .busy(b_busy), .err_oob(b_oob)
  );

  // Timeline model: expected outputs per cycle, filled in when a grant or
  // clear is decided.
  bit [3:0]   e_en   [2][MAXC];
  bit         e_busy [2][MAXC];
  bit         e_clr  [2][MAXC];
  bit         e_oob  [2][MAXC];
  int         idle_at  [2];
  int         rr       [2];
  int         d_at     [2];
  int         last_gnt [2];
  logic [7:0] cur_d    [2];
  logic [7:0] d_new    [2];
  bit         prev_rst;

  // Requester-side stimulus state.
  bit         rv [2][NREQ];
  logic [1:0] ra [2][NREQ];
  logic [7:0] rd [2][NREQ];
  int         clr_left [2];
  int         rst_left;
  bit         arm_rst;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int c);
    for (int k = 0; k < 2; k++) begin
      logic [3:0] o_ready, o_en, x_ready;
      logic [7:0] o_d;
      logic       o_done, o_rst, o_busy, o_oob;
      logic [1:0] addr;
      string      p;
      int         g;
      p = $sformatf("%s@%0d", (k == 0) ? "a" : "b", c);
      if (k == 0) begin
        o_ready = a_ready; o_en = a_lat_en; o_d = a_lat_d; o_done = a_clr_done;
        o_rst = a_lat_rst; o_busy = a_busy; o_oob = a_oob;
      end else begin
        o_ready = b_ready; o_en = {1'b0, b_lat_en}; o_d = b_lat_d; o_done = b_clr_done;
        o_rst = b_lat_rst; o_busy = b_busy; o_oob = b_oob;
      end
      last_gnt[k] = -1;
      if (d_at[k] == c) cur_d[k] = d_new[k];
      if (rst) begin
        check({p, " lat_rst"}, 32'(o_rst), 32'd1);
        if (prev_rst) begin
          check({p, " rst lat_en"}, 32'(o_en), 32'd0);
          check({p, " rst busy"}, 32'(o_busy), 32'd0);
          check({p, " rst lat_d"}, 32'(o_d), 32'd0);
          check({p, " rst clr_done"}, 32'(o_done), 32'd0);
          check({p, " rst err_oob"}, 32'(o_oob), 32'd0);
        end
      end else begin
        x_ready = '0;
        g = -1;
        if (c >= idle_at[k] && !clr_req[k]) begin
          for (int j = 0; j < NREQ; j++) begin
            int r;
            r = (rr[k] + j) % NREQ;
            if (g < 0 && req_valid[k][r]) g = r;
          end
        end
        if (g >= 0) x_ready[g] = 1'b1;
        check({p, " req_ready"}, 32'(o_ready), 32'(x_ready));
        check({p, " lat_d"}, 32'(o_d), 32'(cur_d[k]));
        check({p, " lat_en"}, 32'(o_en), 32'(e_en[k][c]));
        check({p, " busy"}, 32'(o_busy), 32'(e_busy[k][c]));
        check({p, " err_oob"}, 32'(o_oob), 32'(e_oob[k][c]));
        check({p, " clr_done"}, 32'(o_done), 32'(e_clr[k][c]));
        check({p, " lat_rst"}, 32'(o_rst), 32'(e_clr[k][c]));
        if (c >= idle_at[k]) begin
          if (clr_req[k]) begin
            e_clr[k][c+1]  = 1'b1;
            e_busy[k][c+1] = 1'b1;
            idle_at[k]     = c + 2;
          end else if (g >= 0) begin
            addr        = req_addr[k][g*AW +: AW];
            last_gnt[k] = g;
            rr[k]       = (g + 1) % NREQ;
            d_new[k]    = req_data[k][g*8 +: 8];
            d_at[k]     = c + 1;
            for (int q = c + 1; q <= c + s_p[k] + h_p[k] + 1; q++) e_busy[k][q] = 1'b1;
            if (int'(addr) < nl_p[k]) e_en[k][c+s_p[k]+1] = 4'(1 << addr);
            else e_oob[k][c+s_p[k]+1] = 1'b1;
            idle_at[k] = c + s_p[k] + h_p[k] + 2;
          end
        end
      end
    end
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        idle_at[k] = c + 1;
        rr[k]      = 0;
        cur_d[k]   = 8'h00;
        d_at[k]    = -1;
        for (int q = c + 1; q <= c + 24; q++) begin
          e_en[k][q] = '0; e_busy[k][q] = 1'b0; e_clr[k][q] = 1'b0; e_oob[k][q] = 1'b0;
        end
      end
    end
    prev_rst = rst;
  endtask

  task automatic raise(input int k, input int i, input logic [1:0] a, input logic [7:0] d);
    rv[k][i] = 1'b1;
    ra[k][i] = a;
    rd[k][i] = d;
  endtask

  task automatic drive(input int c);
    if (arm_rst && e_en[0][c] != 4'd0) begin
      rst_left = 2;
      arm_rst  = 1'b0;
    end
    if (c >= 130 && rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
    rst = (c < 4) || (rst_left > 0);
    if (rst_left > 0) rst_left--;
    for (int k = 0; k < 2; k++) begin
      if (last_gnt[k] >= 0) rv[k][last_gnt[k]] = 1'b0;
      clr_req[k] = 1'b0;
      if (c == 6) begin
        if (k == 0) raise(0, 1, 2'd2, 8'hA5);
        else begin
          raise(1, 1, 2'd3, 8'h3C);
          raise(1, 2, 2'd0, 8'hC3);
        end
      end
      if ((c >= 20 && c < 60) || (c >= 110 && c < 125)) begin
        for (int i = 0; i < NREQ; i++)
          if (!rv[k][i]) raise(k, i, 2'($urandom_range(0, 3)), 8'($urandom));
      end
      if (c == 60 || c == 125) for (int i = 0; i < NREQ; i++) rv[k][i] = 1'b0;
      if (c == 70) begin
        raise(k, 0, 2'd1, 8'h11);
        clr_req[k] = 1'b1;
      end
      if (c >= 76 && c <= 80) clr_req[k] = 1'b1;
      if (c == 92) begin
        raise(k, 2, 2'd1, 8'h5A);
        arm_rst = 1'b1;
      end
      if (c >= 130) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!rv[k][i]) begin
            if ($urandom_range(0, 2) == 0) raise(k, i, 2'($urandom_range(0, 3)), 8'($urandom));
          end else if ($urandom_range(0, 15) == 0) begin
            rv[k][i] = 1'b0;
          end
        end
        if (clr_left[k] > 0) begin
          clr_req[k] = 1'b1;
          clr_left[k]--;
        end else if ($urandom_range(0, 24) == 0) begin
          clr_left[k] = $urandom_range(1, 3);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        req_valid[k][i]          = rv[k][i];
        req_addr[k][i*AW +: AW]  = ra[k][i];
        req_data[k][i*8 +: 8]    = rd[k][i];
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    prev_rst = 1'b0;
    rst_left = 0;
    arm_rst  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0;
      req_addr[k]  = '0;
      req_data[k]  = '0;
      clr_req[k]   = 1'b0;
      idle_at[k]   = 0;
      rr[k]        = 0;
      d_at[k]      = -1;
      last_gnt[k]  = -1;
      cur_d[k]     = 8'h00;
      d_new[k]     = 8'h00;
      clr_left[k]  = 0;
      for (int i = 0; i < NREQ; i++) begin
        rv[k][i] = 1'b0;
        ra[k][i] = '0;
        rd[k][i] = '0;
      end
    end
    for (int c = 0; c < LAST; c++) begin
      @(posedge clk);
      #1;
      drive(c);
      @(negedge clk);
      model_step(c);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
